// File: rtl/mips_ctrl_pkg.sv
// Shared types and defaults for the data-cache miss stall controller.
// Holds the miss-sequence state encoding and default latency constants.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBACK,
        FETCH,
        FILL
    } stall_state_t;

    localparam int unsigned MEM_LATENCY_DEF   = 4;
    localparam int unsigned DIRTY_PENALTY_DEF = 4;

    // Counter width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stall_timer.sv
// Loadable down-counter shared by the WBACK and FETCH phases.
// Ports: clk, rst_b (sync active-low), load/load_val, done (cnt==0).
module stall_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Stops at zero; the FSM reloads it on every phase entry.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mem_stall_ctrl.sv
// Data-cache miss sequencer: drives pipeline freeze, memory strobes, fill.
// Ports: clk, rst_b, mem_req, cache_hit, cache_dirty, halted_in ->
//   freeze, mem_read, mem_write, cache_fill, busy, halted, stall_cycles.
// Macro MEM_STALL_STATS_EN enables the saturating stall_cycles counter.
module mem_stall_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY   = MEM_LATENCY_DEF,
    parameter int unsigned DIRTY_PENALTY = DIRTY_PENALTY_DEF
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        mem_req,
    input  logic        cache_hit,
    input  logic        cache_dirty,
    input  logic        halted_in,
    output logic        freeze,
    output logic        mem_read,
    output logic        mem_write,
    output logic        cache_fill,
    output logic        busy,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CW = cnt_width(MEM_LATENCY, DIRTY_PENALTY);
    localparam logic [CW-1:0] MEM_LD = CW'(MEM_LATENCY - 1);
    localparam logic [CW-1:0] DP_LD  = CW'(DIRTY_PENALTY - 1);

    stall_state_t state_q;
    stall_state_t state_d;
    logic         halted_q;
    logic         halted_d;
    logic         tmr_load;
    logic [CW-1:0] tmr_val;
    logic         tmr_done;
    logic         miss;
    logic         miss_start;

    stall_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_b    (rst_b),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign miss = mem_req && !cache_hit;
    // A halt arriving with a miss wins: no new sequence is started.
    assign miss_start = miss && !halted_q && !halted_in;

    always_comb begin
        state_d    = state_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        cache_fill = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_start) begin
                    tmr_load = 1'b1;
                    if (cache_dirty) begin
                        state_d = WBACK;
                        tmr_val = DP_LD;
                    end else begin
                        state_d = FETCH;
                        tmr_val = MEM_LD;
                    end
                end
            end
            WBACK: begin
                mem_write = 1'b1;
                if (tmr_done) begin
                    state_d  = FETCH;
                    tmr_load = 1'b1;
                    tmr_val  = MEM_LD;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (tmr_done) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_fill = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign halted_d = halted_q || halted_in;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    assign busy   = (state_q != IDLE);
    // Combinational so the miss cycle itself is already frozen.
    assign freeze = busy || miss || halted_q;
    assign halted = halted_q;

`ifdef MEM_STALL_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (freeze && !halted_q && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
